// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake.
// Each request is held for LATENCY wait cycles, then committed and answered.
module data_mem_responder #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic [3:0]          req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err
);

  localparam int unsigned IDX_W  = ADDR_LEN - 2;
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_commit;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic [ADDR_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_wdata;
  logic [3:0]          r_be;
  logic                r_resp_valid;
  logic [DATA_LEN-1:0] r_resp_rdata;
  logic                r_resp_err;
  logic [DATA_LEN-1:0] r_mem [DEPTH];

  // In IDLE the live request is used so a zero-latency build can commit on the accept edge.
  logic                w_cur_write;
  logic [ADDR_LEN-1:0] w_cur_addr;
  logic [DATA_LEN-1:0] w_cur_wdata;
  logic [3:0]          w_cur_be;
  logic [IDX_W-1:0]    w_idx_full;
  logic [MEM_AW-1:0]   w_idx;
  logic                w_err;

  assign w_cur_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_cur_be    = (r_state == S_IDLE) ? req_be    : r_be;

  // Full-width index compare so upper address bits never alias into storage.
  assign w_idx_full = w_cur_addr[ADDR_LEN-1:2];
  assign w_idx      = w_cur_addr[MEM_AW+1:2];
  assign w_err      = (w_cur_addr[1:0] != 2'b00) || (w_idx_full >= IDX_W'(DEPTH));

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 0) begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (!w_cur_write && !w_err) ? r_mem[w_idx] : '0;
      end else if ((r_state == S_RESP) && resp_ready) begin
        r_resp_valid <= 1'b0;
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b0;
      end
    end
  end

  // Storage: cleared by reset, written byte-wise only at commit of a legal store.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_commit && w_cur_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_be[b]) r_mem[w_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, corner sequences,
// randomized traffic against a byte-level memory model, and a zero-latency build.
module tb_data_mem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        resp_valid0, resp_ready0, resp_err0;
  logic [31:0] resp_rdata0;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: memory as an array of words, errors by plain address arithmetic.
  task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rd, output logic er);
    er = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[a / 4][8*b +: 8] = d[8*b +: 8];
      end else begin
        rd = m_mem[a / 4];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
  endtask

  // One transaction; noise on the request port while busy, `hold` cycles of backpressure.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er);
    int edges;
    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    edges = 0;
    while (!resp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 64'(edges), 64'(LAT));
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_stable", {29'b0, resp_valid, req_ready, resp_err, resp_rdata},
            {29'b0, 1'b1, 1'b0, er, rd});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("handshake", {30'b0, resp_valid, req_ready, resp_err, resp_rdata},
          {30'b0, 1'b0, 1'b1, 1'b0, 32'h0});
  endtask

  initial begin
    logic [31:0] rd, mrd, a;
    logic        er, mer, w;
    int          sel;

    tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  4'hF, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344,  4'hF, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD,  4'h5, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0020, 32'h0,          4'hF, 32'h11BB_33DD, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0013, 32'h0,          4'hF, 32'h0000_0000, 1'b1};
    tbl[7]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF,  4'hF, 32'h0000_0000, 1'b1};
    tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0000, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0010, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0010, 32'h0,          4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_03FC, 32'h0102_0304,  4'hF, 32'h0000_0000, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_03FC, 32'h0,          4'hF, 32'h0102_0304, 1'b0};
    tbl[13] = '{1'b0, 32'h8000_0010, 32'h0,          4'hF, 32'h0000_0000, 1'b1};
    tbl[14] = '{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_BEEF, 1'b0};

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
    resp_ready0 = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("reset_state", {resp_valid, req_ready, resp_err, resp_rdata},
          {1'b0, 1'b1, 1'b0, 32'h0});

    // Directed table; entry 2 gets 5 cycles of backpressure.
    for (int i = 0; i < 15; i++) begin
      do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, (i == 2) ? 5 : (i % 2), rd, er);
      model_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, mrd, mer);
      check($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
    end

    // Exactly one response: nothing reappears after the handshake.
    @(posedge clk); #1;
    check("no_extra_resp", 64'(resp_valid), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom % 8);
      if (sel == 0)      a = {24'h0, 4'($urandom), 2'b00, 2'($urandom % 3 + 1)};
      else if (sel == 1) a = 32'h400 + ($urandom & 32'hFFFF_FFF0) % 32'hFFFF_F000;
      else               a = {24'h0, 4'($urandom), 2'b00, 2'b00};
      w = 1'($urandom);
      do_txn(w, a, $urandom, 4'($urandom), int'($urandom % 3), rd, er);
      model_txn(w, a, req_wdata_last(w, a), 4'h0, mrd, mer);
    end

    // Mid-operation reset drops the pending store and clears storage.
    do_txn(1'b1, 32'h8, 32'h1234_5678, 4'hF, 0, rd, er);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_resp", 64'(resp_valid), 64'd0);
    end
    rst = 1'b1;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", {62'b0, resp_valid, req_ready}, {62'b0, 1'b0, 1'b1});
    end
    model_clear();
    do_txn(1'b0, 32'h8, 32'h0, 4'hF, 0, rd, er);
    check("post_rst_load", {31'b0, er, rd}, {31'b0, 1'b0, 32'h0});

    // Zero-latency build: response on the cycle after accept.
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h44; req_wdata0 = 32'h5A5A_0F0F; req_be0 = 4'hF;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("lat0_store_resp", {30'b0, resp_valid0, req_ready0, resp_err0, resp_rdata0},
          {30'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    resp_ready0 = 1'b1;
    @(posedge clk); #1;
    resp_ready0 = 1'b0;
    check("lat0_idle", {62'b0, resp_valid0, req_ready0}, {62'b0, 1'b0, 1'b1});
    req_valid0 = 1'b1; req_write0 = 1'b0;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("lat0_load_resp", {31'b0, resp_valid0, resp_rdata0}, {31'b0, 1'b1, 32'h5A5A_0F0F});
    resp_ready0 = 1'b1;
    @(posedge clk); #1;
    resp_ready0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Random-phase bookkeeping: captured at accept so the model sees the real store payload.
  logic [31:0] acc_wdata, acc_addr;
  logic [3:0]  acc_be;
  logic        acc_write;
  always @(posedge clk) begin
    if (rst && req_valid && req_ready) begin
      acc_wdata <= req_wdata;
      acc_addr  <= req_addr;
      acc_be    <= req_be;
      acc_write <= req_write;
    end
  end

  // Applies the last accepted random transaction to the model and checks the DUT response.
  logic [31:0] last_rd;
  logic        last_er;
  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      last_rd <= resp_rdata;
      last_er <= resp_err;
    end
  end

  function automatic logic [31:0] req_wdata_last(input logic w, input logic [31:0] a);
    logic [31:0] mrd;
    logic        mer;
    mrd = 32'h0;
    mer = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    if (!mer) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (acc_be[b]) m_mem[a / 4][8*b +: 8] = acc_wdata[8*b +: 8];
      end else begin
        mrd = m_mem[a / 4];
      end
    end
    n_total++;
    if ({last_er, last_rd} === {mer, mrd}) n_pass++;
    else $display("FAIL rand_resp addr %h wr %0d: got err %0d data %h expected err %0d data %h",
                  a, w, last_er, last_rd, mer, mrd);
    return 32'h0;
  endfunction

endmodule
